deadlock_kernel_monitor_gen2: RTL
=================================

// Module: deadlock_kernel_monitor_gen2
// PURPOSE
//  Parametrised dataflow deadlock monitor for HLS kernel co-simulation.
//  Takes per-process idle/block vectors and per-AXIS-channel block flags.
//  Declares deadlock only after a programmable number of consecutive quiet-but-blocked cycles.
//  Reports the culprit process, a stall counter and per-channel AXIS stall flags.
//  Sits under the kernel monitor top, replacing the fixed-size single-cycle idx monitor.
// PARAMETERS
//  N_PROC       4     number of monitored dataflow processes (>=1)
//  N_AXIS       2     number of monitored AXIS channels (>=1)
//  THRESH       16    consecutive suspect cycles to declare deadlock (>=1)
//  CNT_W        16    stall_count width; counter saturates
//  AXIS_THRESH  1024  consecutive blocked cycles to flag an AXIS stall (>=1, < 2**AXIS_CNT_W)
//  AXIS_CNT_W   12    per-channel AXIS counter width; counter saturates
//  IDX_W        local, $clog2(N_PROC) (min 1)
// PORTS
//  kernel_monitor_clock  in   1        single clock, all state on rising edge
//  kernel_monitor_reset  in   1        asynchronous, active-low reset
//  enable                in   1        monitoring enable
//  clear                 in   1        sync clear of sticky deadlock state
//  inst_idle_sigs        in   N_PROC   process idle flags
//  inst_block_sigs       in   N_PROC   process blocked flags (FIFO full/empty, ap_done&~ap_continue)
//  axis_block_sigs       in   N_AXIS   AXIS channel blocked flags
//  kernel_block          out  1        high while state==DEADLOCK
//  deadlock_pulse        out  1        one-cycle pulse on entry to DEADLOCK
//  culprit_idx           out  IDX_W    lowest blocked process index, latched on entry
//  stall_count           out  CNT_W    consecutive suspect cycles, saturating
//  axis_stall            out  N_AXIS   channel i blocked >= AXIS_THRESH cycles
//  state                 out  2        IDLE=0, MONITOR=1, SUSPECT=2, DEADLOCK=3
// BEHAVIOUR
//  Reset: state=IDLE; all counters, outputs and snapshot are 0.
//  cond = enable & &(inst_idle_sigs|inst_block_sigs) & |inst_block_sigs (registered-path only).
//  FSM, evaluated each rising edge:
//   IDLE:     enable -> MONITOR; counter held 0.
//   MONITOR:  ~enable -> IDLE; cond -> SUSPECT with cnt=1.
//   SUSPECT:  ~enable -> IDLE, cnt=0; ~cond -> MONITOR, cnt=0.
//             cond & cnt==THRESH-1 -> DEADLOCK (pulse, latch culprit); else cnt++.
//   DEADLOCK: sticky, ignores enable. clear -> MONITOR with cnt=0; else stays.
//  THRESH==1: MONITOR with cond goes straight to DEADLOCK.
//  Latency: kernel_block rises on the edge that samples the THRESH-th consecutive cond cycle.
//  Simultaneous clear and cond in DEADLOCK: clear wins -> MONITOR; cond re-evaluated next edge.
//  stall_count:
//   mirrors cnt outside DEADLOCK.
//   in DEADLOCK, increments while cond holds and holds otherwise.
//   saturates at 2**CNT_W-1 and never wraps.
//  culprit_idx: priority encode of inst_block_sigs (lowest index) on the entry edge; held until the next entry.
//  AXIS channel i:
//   counter increments while axis_block_sigs[i]=1 and clears to 0 when it is 0.
//   counter saturates at 2**AXIS_CNT_W-1.
//   axis_stall[i] = (counter >= AXIS_THRESH), registered.
//   unaffected by enable and clear.
//  Reset mid-operation: immediate return to reset values, regardless of clock.
// CONFIGURATION
//  DEADLOCK_MON_SNAPSHOT_EN defined:
//   adds output snapshot_block [N_PROC].
//   captures inst_block_sigs on the entry edge; cleared by reset only.
//   adds sim-only $display of time and culprit on the deadlock_pulse edge.
//  Undefined: no snapshot port or register, no $display; all other behaviour identical.
// TESTING
//  Reset with all inputs 0 -> every output 0, state=0.
//  Vectors and steps, N_PROC=4, THRESH=16, enable=1:
//   idle=4'b1011, block=4'b0100 held 16 cycles -> kernel_block high after 16th edge, deadlock_pulse 1 cycle, culprit_idx=2.
//   same pattern 15 cycles then block=0 -> never DEADLOCK; state back to 1, stall_count=0.
//   in DEADLOCK, pulse clear with cond still high -> state=1 next edge, then SUSPECT, re-deadlock after 16 more cycles.
//   drop enable while in DEADLOCK -> stays 3; raise clear with enable=0 -> MONITOR then IDLE.
//  axis_block_sigs[1]=1 for 1024 cycles -> axis_stall[1] high from edge 1024; drop it -> axis_stall[1]=0 one edge later.
//  Async reset asserted mid-SUSPECT (cnt=7) -> outputs 0 immediately; release -> IDLE, no spurious pulse.

Source files
------------

// File: rtl/deadlock_kernel_monitor_gen2.sv
// deadlock_kernel_monitor_gen2
//   Dataflow deadlock monitor for HLS kernel co-simulation. Declares deadlock
//   after THRESH consecutive cycles in which every process is idle or blocked
//   and at least one process is blocked. Deadlock is sticky until clear.
//   Also flags AXIS channels that have been blocked for AXIS_THRESH cycles.
//
// Ports
//   kernel_monitor_clock  rising-edge clock
//   kernel_monitor_reset  asynchronous active-low reset
//   enable / clear        monitoring enable, sync clear of sticky deadlock
//   inst_idle_sigs        per-process idle flags       [N_PROC]
//   inst_block_sigs       per-process blocked flags    [N_PROC]
//   axis_block_sigs       per-channel AXIS blocked     [N_AXIS]
//   kernel_block          high while in DEADLOCK
//   deadlock_pulse        one-cycle pulse on DEADLOCK entry
//   culprit_idx           lowest blocked process index, latched on entry
//   stall_count           saturating count of consecutive suspect cycles
//   axis_stall            per-channel long-stall flags
//   state                 IDLE=0 MONITOR=1 SUSPECT=2 DEADLOCK=3
//
// Optional feature (macro DEADLOCK_MON_SNAPSHOT_EN)
//   Adds snapshot_block [N_PROC], the inst_block_sigs captured on DEADLOCK
//   entry (cleared by reset only), plus a simulation message on entry.

module deadlock_kernel_monitor_gen2 #(
    parameter int unsigned N_PROC      = 4,
    parameter int unsigned N_AXIS      = 2,
    parameter int unsigned THRESH      = 16,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned AXIS_THRESH = 1024,
    parameter int unsigned AXIS_CNT_W  = 12,
    localparam int unsigned IDX_W      = (N_PROC > 1) ? $clog2(N_PROC) : 1
) (
    input  logic                kernel_monitor_clock,
    input  logic                kernel_monitor_reset,
    input  logic                enable,
    input  logic                clear,
    input  logic [N_PROC-1:0]   inst_idle_sigs,
    input  logic [N_PROC-1:0]   inst_block_sigs,
    input  logic [N_AXIS-1:0]   axis_block_sigs,
    output logic                kernel_block,
    output logic                deadlock_pulse,
    output logic [IDX_W-1:0]    culprit_idx,
    output logic [CNT_W-1:0]    stall_count,
    output logic [N_AXIS-1:0]   axis_stall,
    output logic [1:0]          state
`ifdef DEADLOCK_MON_SNAPSHOT_EN
    ,
    output logic [N_PROC-1:0]   snapshot_block
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MONITOR  = 2'd1,
        ST_SUSPECT  = 2'd2,
        ST_DEADLOCK = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]      THR_M1   = CNT_W'(THRESH - 1);
    localparam logic [AXIS_CNT_W-1:0] AXIS_MAX = {AXIS_CNT_W{1'b1}};
    localparam logic [AXIS_CNT_W-1:0] AXIS_THR = AXIS_CNT_W'(AXIS_THRESH);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_kernel_block;
    logic              r_pulse;
    logic [IDX_W-1:0]  r_culprit;

    logic              w_cond;
    logic              w_enter;
    logic [IDX_W-1:0]  w_prio;
    logic [CNT_W-1:0]  w_cnt_inc;

    // Quiet-but-blocked: every process idle or blocked, at least one blocked.
    assign w_cond = enable & (&(inst_idle_sigs | inst_block_sigs)) & (|inst_block_sigs);

    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    // Edge on which DEADLOCK is entered; THRESH==1 skips SUSPECT.
    assign w_enter = w_cond &
                     (((r_state == ST_MONITOR) && (THRESH == 1)) ||
                      ((r_state == ST_SUSPECT) && (r_cnt == THR_M1)));

    // Lowest-index blocked process.
    always_comb begin
        w_prio = '0;
        for (int i = int'(N_PROC) - 1; i >= 0; i--) begin
            if (inst_block_sigs[i]) begin
                w_prio = IDX_W'(i);
            end
        end
    end

    // Main FSM and suspect/stall counter.
    always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
        if (!kernel_monitor_reset) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_kernel_block <= 1'b0;
        end else begin
            r_kernel_block <= w_enter | ((r_state == ST_DEADLOCK) & ~clear);
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (enable) begin
                        r_state <= ST_MONITOR;
                    end
                end
                ST_MONITOR: begin
                    if (!enable) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (w_cond) begin
                        r_cnt   <= CNT_W'(1);
                        r_state <= w_enter ? ST_DEADLOCK : ST_SUSPECT;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                ST_SUSPECT: begin
                    if (!enable) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (!w_cond) begin
                        r_state <= ST_MONITOR;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_enter) begin
                            r_state <= ST_DEADLOCK;
                        end
                    end
                end
                ST_DEADLOCK: begin
                    // Sticky: only clear leaves; stall count keeps growing under cond.
                    if (clear) begin
                        r_state <= ST_MONITOR;
                        r_cnt   <= '0;
                    end else if (w_cond) begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Entry pulse and culprit latch.
    always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
        if (!kernel_monitor_reset) begin
            r_pulse   <= 1'b0;
            r_culprit <= '0;
        end else begin
            r_pulse <= w_enter;
            if (w_enter) begin
                r_culprit <= w_prio;
            end
        end
    end

`ifdef DEADLOCK_MON_SNAPSHOT_EN
    logic [N_PROC-1:0] r_snapshot;

    // Blocked-vector snapshot on entry; survives clear.
    always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
        if (!kernel_monitor_reset) begin
            r_snapshot <= '0;
        end else if (w_enter) begin
            r_snapshot <= inst_block_sigs;
            $display("%0t deadlock_kernel_monitor_gen2: deadlock, culprit %0d", $time, w_prio);
        end
    end

    assign snapshot_block = r_snapshot;
`endif

    // Per-channel AXIS stall counters, independent of enable/clear.
    for (genvar g = 0; g < int'(N_AXIS); g++) begin : g_axis
        logic [AXIS_CNT_W-1:0] r_axis_cnt;
        logic [AXIS_CNT_W-1:0] w_axis_nxt;
        logic                  r_axis_stall;

        assign w_axis_nxt = !axis_block_sigs[g]    ? '0 :
                            (r_axis_cnt == AXIS_MAX) ? r_axis_cnt :
                                                       r_axis_cnt + AXIS_CNT_W'(1);

        // Flag from the next count so it rises on the AXIS_THRESH-th blocked edge.
        always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
            if (!kernel_monitor_reset) begin
                r_axis_cnt   <= '0;
                r_axis_stall <= 1'b0;
            end else begin
                r_axis_cnt   <= w_axis_nxt;
                r_axis_stall <= (w_axis_nxt >= AXIS_THR);
            end
        end

        assign axis_stall[g] = r_axis_stall;
    end

    assign kernel_block   = r_kernel_block;
    assign deadlock_pulse = r_pulse;
    assign culprit_idx    = r_culprit;
    assign stall_count    = r_cnt;
    assign state          = r_state;

endmodule
